// File: rtl/i2c_stream_writer.sv
`default_nettype none
// ============================================================================
// Module : i2c_stream_writer
// Write-only I2C master: START, address+W, control byte, streamed data, STOP.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_stream_writer #(
    parameter int         CLK_DIV   = 4,
    parameter logic [6:0] DEV_ADDR  = 7'h3D,
    parameter bit         CHECK_ACK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ctrl,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    localparam logic [15:0] c_DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [7:0]  c_ADDR_BYTE = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_CTRL  = 3'd3,
        S_DATA  = 3'd4,
        S_ACK   = 3'd5,
        S_WAIT  = 3'd6,
        S_STOP  = 3'd7
    } state_t;

    state_t      r_state;
    state_t      r_prev;
    logic [15:0] r_div;
    logic [1:0]  r_q;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_ctrl;
    logic        r_last;

    logic w_run;
    logic w_tick;

    assign w_run  = (r_state != S_IDLE) && (r_state != S_WAIT);
    assign w_tick = w_run && (r_div == c_DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_prev    <= S_IDLE;
            r_div     <= 16'd0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
            r_ctrl    <= 8'd0;
            r_last    <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            nack      <= 1'b0;
            din_ready <= 1'b0;
        end else begin
            done      <= 1'b0;
            din_ready <= 1'b0;

            if (!w_run || w_tick)
                r_div <= 16'd0;
            else
                r_div <= r_div + 16'd1;

            case (r_state)
                S_IDLE: begin
                    scl_oe <= 1'b0;
                    sda_oe <= 1'b0;
                    r_q    <= 2'd0;
                    if (start) begin
                        r_ctrl  <= ctrl;
                        nack    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: if (w_tick) begin
                    case (r_q)
                        2'd0: begin
                            sda_oe <= 1'b1;
                            r_q    <= 2'd1;
                        end
                        2'd1: begin
                            scl_oe <= 1'b1;
                            r_q    <= 2'd2;
                        end
                        default: begin
                            r_q     <= 2'd0;
                            r_bit   <= 3'd0;
                            r_shift <= c_ADDR_BYTE;
                            sda_oe  <= ~c_ADDR_BYTE[7];
                            r_state <= S_ADDR;
                        end
                    endcase
                end

                // Each quarter's line levels are registered on the tick that enters it.
                S_ADDR, S_CTRL, S_DATA: if (w_tick) begin
                    case (r_q)
                        2'd0: begin
                            scl_oe <= 1'b0;
                            r_q    <= 2'd1;
                        end
                        2'd1: r_q <= 2'd2;
                        2'd2: begin
                            scl_oe <= 1'b1;
                            r_q    <= 2'd3;
                        end
                        default: begin
                            r_q <= 2'd0;
                            if (r_bit == 3'd7) begin
                                r_bit   <= 3'd0;
                                sda_oe  <= 1'b0;
                                r_prev  <= r_state;
                                r_state <= S_ACK;
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_shift <= {r_shift[6:0], 1'b0};
                                sda_oe  <= ~r_shift[6];
                            end
                        end
                    endcase
                end

                S_ACK: if (w_tick) begin
                    case (r_q)
                        2'd0: begin
                            scl_oe <= 1'b0;
                            r_q    <= 2'd1;
                        end
                        2'd1: begin
                            if (CHECK_ACK && sda_in)
                                nack <= 1'b1;
                            r_q <= 2'd2;
                        end
                        2'd2: begin
                            scl_oe <= 1'b1;
                            r_q    <= 2'd3;
                        end
                        default: begin
                            r_q <= 2'd0;
                            // A NACK finishes its slot first so SDA only moves under SCL low.
                            if (nack || (r_prev == S_DATA && r_last)) begin
                                sda_oe  <= 1'b1;
                                r_state <= S_STOP;
                            end else if (r_prev == S_ADDR) begin
                                r_shift <= r_ctrl;
                                sda_oe  <= ~r_ctrl[7];
                                r_state <= S_CTRL;
                            end else if (din_valid) begin
                                din_ready <= 1'b1;
                                r_shift   <= din;
                                r_last    <= din_last;
                                sda_oe    <= ~din[7];
                                r_state   <= S_DATA;
                            end else begin
                                r_state <= S_WAIT;
                            end
                        end
                    endcase
                end

                S_WAIT: begin
                    if (din_valid) begin
                        din_ready <= 1'b1;
                        r_shift   <= din;
                        r_last    <= din_last;
                        sda_oe    <= ~din[7];
                        r_q       <= 2'd0;
                        r_state   <= S_DATA;
                    end
                end

                S_STOP: if (w_tick) begin
                    case (r_q)
                        2'd0: begin
                            scl_oe <= 1'b0;
                            r_q    <= 2'd1;
                        end
                        2'd1: begin
                            sda_oe <= 1'b0;
                            r_q    <= 2'd2;
                        end
                        default: begin
                            r_q     <= 2'd0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    endcase
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_stream_writer.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_stream_writer
// Self-checking bench: I2C slave/decoder, stream source and transaction model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2c_stream_writer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ctrl;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       sda_in;
    logic       scl_oe1, sda_oe1, busy1, done1, nack1, rdy1;
    logic       scl_oe2, sda_oe2, busy2, done2, nack2, rdy2;

    logic       follow2;
    logic       slave_pull;
    logic       scl_oe_f, sda_oe_f, busy_f, done_f, rdy_f;

    assign scl_oe_f = follow2 ? scl_oe2 : scl_oe1;
    assign sda_oe_f = follow2 ? sda_oe2 : sda_oe1;
    assign busy_f   = follow2 ? busy2   : busy1;
    assign done_f   = follow2 ? done2   : done1;
    assign rdy_f    = follow2 ? rdy2    : rdy1;
    assign sda_in   = slave_pull ? 1'b0 : ~sda_oe_f;

    always #5 clk = ~clk;

    i2c_stream_writer #(.CLK_DIV(D), .DEV_ADDR(7'h3D), .CHECK_ACK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .din(din),
        .din_valid(din_valid), .din_last(din_last), .din_ready(rdy1),
        .sda_in(sda_in), .scl_oe(scl_oe1), .sda_oe(sda_oe1),
        .busy(busy1), .done(done1), .nack(nack1));

    i2c_stream_writer #(.CLK_DIV(D), .DEV_ADDR(7'h3D), .CHECK_ACK(1'b0)) dut_noack (
        .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .din(din),
        .din_valid(din_valid), .din_last(din_last), .din_ready(rdy2),
        .sda_in(sda_in), .scl_oe(scl_oe2), .sda_oe(sda_oe2),
        .busy(busy2), .done(done2), .nack(nack2));

    int total = 0;
    int bad   = 0;

    // Transaction description and observed results
    logic [7:0] t_data [8];
    int         t_stall[8];
    int         t_n;
    logic [7:0] t_ctrl;
    bit         t_nack_all;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         busy_c[2], done_c[2], rdy_c[2];
    bit         stall_bad;

    function automatic int boundary(input int j, input int stall_before);
        return D * (3 + 36 * (2 + j)) - 1 + stall_before;
    endfunction

    function automatic int exp_busy();
        int s = 0;
        for (int i = 0; i < t_n; i++) s += t_stall[i];
        return D * (6 + 36 * (2 + t_n)) + s;
    endfunction

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(8'h7A);
        exp_q.push_back(t_ctrl);
        for (int i = 0; i < t_n; i++) exp_q.push_back(t_data[i]);
    endtask

    // Runs one transaction: source, slave and bus decoder all act at negedges.
    task automatic run_txn(input int abort_at, output bit aborted);
        int idx, j, stall_sum, post, f, tb;
        bit seen_done, prev_scl, prev_sda, scl, sda;
        logic prev_scl_oe, prev_sda_oe;
        int bitcnt;
        logic [7:0] sh;
        aborted = 1'b0;
        got.delete();
        for (int k = 0; k < 2; k++) begin busy_c[k] = 0; done_c[k] = 0; rdy_c[k] = 0; end
        stall_bad = 1'b0;
        f = follow2 ? 1 : 0;
        @(negedge clk);
        start = 1'b1; ctrl = t_ctrl; j = 0;
        din = t_data[0]; din_last = (t_n == 1); din_valid = (t_stall[0] == 0);
        slave_pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1; bitcnt = 0; sh = 8'h00;
        stall_sum = 0; post = 0; seen_done = 1'b0; idx = 0;
        prev_scl_oe = 1'b0; prev_sda_oe = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (nack1 !== 1'b0) begin bad++; $display("FAIL nack_clear_on_start: got %b want 0", nack1); end
        total++;
        if (busy_f !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy_f); end
        for (int cyc = 0; cyc < 20000 && post < 3; cyc++) begin
            if (busy1) busy_c[0]++;
            if (busy2) busy_c[1]++;
            if (done1) done_c[0]++;
            if (done2) done_c[1]++;
            if (rdy1)  rdy_c[0]++;
            if (rdy2)  rdy_c[1]++;
            idx = busy_c[f] - 1;
            if (abort_at >= 0 && busy_f && idx == abort_at) begin
                aborted = 1'b1;
                return;
            end
            if (done_f) begin
                seen_done = 1'b1;
                total++;
                if (busy_f !== 1'b0) begin bad++; $display("FAIL busy_low_with_done: got %b want 0", busy_f); end
            end
            if (seen_done) post++;
            if (busy_f && j < t_n) begin
                tb = boundary(j, stall_sum);
                if (t_stall[j] > 0 && idx > tb && idx <= tb + t_stall[j])
                    if (scl_oe_f !== 1'b1 || scl_oe_f !== prev_scl_oe || sda_oe_f !== prev_sda_oe)
                        stall_bad = 1'b1;
            end
            if (rdy_f) begin
                tb = (j < t_n) ? boundary(j, stall_sum) + t_stall[j] + 1 : -1;
                total++;
                if (idx != tb) begin
                    bad++;
                    $display("FAIL din_ready_timing byte %0d: busy cycle %0d want %0d", j, idx, tb);
                end
                if (j < t_n) stall_sum += t_stall[j];
                j++;
                if (j < t_n) begin
                    din = t_data[j]; din_last = (j == t_n - 1); din_valid = (t_stall[j] == 0);
                end else begin
                    din_valid = 1'b0;
                end
            end
            if (busy_f && j < t_n && !din_valid && idx == boundary(j, stall_sum) + t_stall[j])
                din_valid = 1'b1;
            // Bus decoder and ACK-driving slave, from the observed line levels
            scl = !scl_oe_f;
            sda = sda_in;
            if (scl && prev_scl && prev_sda && !sda) begin
                bitcnt = 0;
            end else if (scl && !prev_scl) begin
                if (bitcnt < 8) sh = {sh[6:0], sda};
                bitcnt++;
                if (bitcnt == 8) got.push_back(sh);
            end else if (!scl && prev_scl) begin
                if (bitcnt == 8) slave_pull = !t_nack_all;
                else if (bitcnt == 9) begin slave_pull = 1'b0; bitcnt = 0; end
            end
            prev_scl = scl;
            prev_sda = sda_in;
            prev_scl_oe = scl_oe_f;
            prev_sda_oe = sda_oe_f;
            @(negedge clk);
        end
        slave_pull = 1'b0;
        din_valid = 1'b0;
        total++;
        if (!seen_done) begin bad++; $display("FAIL txn_timeout: done never seen"); end
    endtask

    task automatic test_reset();
        total++; if (scl_oe1 !== 1'b0) begin bad++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe1); end
        total++; if (sda_oe1 !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
        total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done1); end
        total++; if (nack1 !== 1'b0) begin bad++; $display("FAIL reset_nack: got %b want 0", nack1); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL reset_din_ready: got %b want 0", rdy1); end
    endtask

    task automatic test_single();
        bit ab;
        t_n = 1; t_ctrl = 8'h00; t_data[0] = 8'hAE; t_stall[0] = 0;
        run_txn(-1, ab);
        build_exp();
        total++; if (busy_c[0] != 456) begin bad++; $display("FAIL single_busy_width: got %0d want 456", busy_c[0]); end
        total++; if (done_c[0] != 1) begin bad++; $display("FAIL single_done_pulses: got %0d want 1", done_c[0]); end
        total++; if (rdy_c[0] != 1) begin bad++; $display("FAIL single_ready_pulses: got %0d want 1", rdy_c[0]); end
        total++; if (nack1 !== 1'b0) begin bad++; $display("FAIL single_nack: got %b want 0", nack1); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL single_byte_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL single_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_stream(input int stall_len);
        bit ab;
        t_n = 3; t_ctrl = 8'h40;
        t_data[0] = 8'h01; t_data[1] = 8'h02; t_data[2] = 8'h03;
        t_stall[0] = 0; t_stall[1] = stall_len; t_stall[2] = 0;
        run_txn(-1, ab);
        build_exp();
        total++; if (busy_c[0] != 744 + stall_len) begin bad++; $display("FAIL stream_busy_width stall=%0d: got %0d want %0d", stall_len, busy_c[0], 744 + stall_len); end
        total++; if (rdy_c[0] != 3) begin bad++; $display("FAIL stream_ready_pulses: got %0d want 3", rdy_c[0]); end
        total++; if (done_c[0] != 1) begin bad++; $display("FAIL stream_done_pulses: got %0d want 1", done_c[0]); end
        total++; if (stall_bad) begin bad++; $display("FAIL stream_stall_lines: got toggles want none"); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL stream_byte_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL stream_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_random(input int iters);
        bit ab;
        for (int it = 0; it < iters; it++) begin
            t_n = $urandom_range(1, 4);
            t_ctrl = ($urandom_range(0, 1) == 1) ? 8'h40 : 8'h00;
            for (int i = 0; i < t_n; i++) begin
                t_data[i] = 8'($urandom);
                t_stall[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            end
            run_txn(-1, ab);
            build_exp();
            total++; if (busy_c[0] != exp_busy()) begin bad++; $display("FAIL rand%0d_busy_width: got %0d want %0d", it, busy_c[0], exp_busy()); end
            total++; if (rdy_c[0] != t_n) begin bad++; $display("FAIL rand%0d_ready_pulses: got %0d want %0d", it, rdy_c[0], t_n); end
            total++; if (stall_bad) begin bad++; $display("FAIL rand%0d_stall_lines: got toggles want none", it); end
            total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_byte_count: got %0d want %0d", it, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, got[i], exp_q[i]); end
            end
        end
    endtask

    // Slave never ACKs: the checking instance aborts, the ignoring one completes.
    task automatic test_nack();
        bit ab;
        t_n = 2; t_ctrl = 8'h40; t_data[0] = 8'($urandom); t_data[1] = 8'($urandom);
        t_stall[0] = 0; t_stall[1] = 0;
        t_nack_all = 1'b1; follow2 = 1'b1;
        run_txn(-1, ab);
        build_exp();
        total++; if (busy_c[0] != D * 42) begin bad++; $display("FAIL nack_busy_width: got %0d want %0d", busy_c[0], D * 42); end
        total++; if (nack1 !== 1'b1) begin bad++; $display("FAIL nack_flag: got %b want 1", nack1); end
        total++; if (rdy_c[0] != 0) begin bad++; $display("FAIL nack_ready_pulses: got %0d want 0", rdy_c[0]); end
        total++; if (done_c[0] != 1) begin bad++; $display("FAIL nack_done_pulses: got %0d want 1", done_c[0]); end
        total++; if (busy_c[1] != exp_busy()) begin bad++; $display("FAIL noack_busy_width: got %0d want %0d", busy_c[1], exp_busy()); end
        total++; if (nack2 !== 1'b0) begin bad++; $display("FAIL noack_nack_flag: got %b want 0", nack2); end
        total++; if (rdy_c[1] != 2) begin bad++; $display("FAIL noack_ready_pulses: got %0d want 2", rdy_c[1]); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL noack_byte_count: got %0d want %0d", got.size(), exp_q.size()); end
        t_nack_all = 1'b0; follow2 = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ab;
        t_n = 2; t_ctrl = 8'h40; t_data[0] = 8'h00; t_data[1] = 8'h55;
        t_stall[0] = 0; t_stall[1] = 0;
        run_txn(D * 75 + 6, ab);
        total++; if (!ab) begin bad++; $display("FAIL reset_abort_point: got not reached want reached"); end
        #2 rst = 1'b1;
        #1;
        total++; if (scl_oe1 !== 1'b0) begin bad++; $display("FAIL async_scl_oe: got %b want 0", scl_oe1); end
        total++; if (sda_oe1 !== 1'b0) begin bad++; $display("FAIL async_sda_oe: got %b want 0", sda_oe1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy1); end
        din_valid = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_single();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ctrl = 8'h00; din = 8'h00;
        din_valid = 1'b0; din_last = 1'b0; follow2 = 1'b0; slave_pull = 1'b0; t_nack_all = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single();
        test_stream(0);
        test_stream(100);
        test_nack();
        test_random(5);
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_stream_writer.md
Name: i2c_stream_writer

Overview:
- Parametrised I2C write-only master: START, 7-bit address + W, control byte, N streamed data bytes, STOP.
- Generalises the fixed single-command OLED sender with:
  - a programmable SCL divider
  - a variable-length data stream over a valid/ready handshake
  - open-drain outputs
  - real ACK sampling with NACK abort.
- Sits between the display init/refresh sequencer (which issues ctrl 8'h00 command or 8'h40 data streams) and the board I2C pins.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period; legal range 2..65535.
- DEV_ADDR, 7'h3D, 7-bit slave address; wire byte is {DEV_ADDR,1'b0} = 8'h7A.
- CHECK_ACK, 1, 1 = sample ACK and abort on NACK; 0 = ignore the ACK slot.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begins a transaction when sampled high in IDLE
- ctrl  in  8  control byte, captured on the accepted start
- din  in  8  data byte
- din_valid  in  1  din holds a valid byte
- din_last  in  1  qualifies din: final byte of the transaction
- din_ready  out  1  one-cycle pulse: din/din_last consumed this cycle
- sda_in  in  1  sampled SDA pin level
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- nack  out  1  sticky error; cleared on the next accepted start

Behaviour:
- Reset (async, immediate):
  - scl_oe=0, sda_oe=0; bus is released even if mid-byte.
  - busy=0, done=0, nack=0, din_ready=0; state IDLE; divider and bit counters cleared.
- Quarter tick:
  - Divider counts 0..CLK_DIV-1 while busy; tick on terminal count.
  - All line changes happen only on ticks.
  - Divider is held at 0 in IDLE and in WAIT_DATA.
- States: IDLE, START, ADDR, CTRL, DATA, ACK, WAIT_DATA, STOP.
- IDLE:
  - Lines released.
  - start=1: capture ctrl, clear nack, busy=1 next cycle, go to START.
  - start while busy is ignored.
- START, 3 quarters: (SCL rel, SDA rel) -> (SCL rel, SDA low) -> (SCL low, SDA low).
- Byte states, MSB first, 4 quarters per bit:
  - q0: SCL low, set SDA (bit=0 -> sda_oe=1).
  - q1: release SCL.
  - q2: SCL high.
  - q3: pull SCL low.
- ACK slot, 4 quarters:
  - sda_oe=0; same SCL pattern as a data bit.
  - sda_in sampled on the q1->q2 tick; 1 = NACK.
- Sequence: ADDR -> ACK -> CTRL -> ACK -> data byte boundary.
- Data byte boundary (SCL low):
  - din_valid=1: din_ready pulses 1 cycle, din and din_last latched, go to DATA.
  - din_valid=0: go to WAIT_DATA with SCL held low and SDA unchanged; resume on the cycle din_valid rises (same din_ready pulse rules).
- After each data byte's ACK:
  - latched last=1 -> STOP.
  - otherwise -> next data byte boundary.
- NACK with CHECK_ACK=1:
  - nack=1, go directly to STOP.
  - No further din_ready pulses for this transaction.
- STOP, 3 quarters: (SCL low, SDA low) -> (SCL rel, SDA low) -> (SCL rel, SDA rel).
  - On the final tick: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- start and done are independent: a start sampled in the cycle done is high is accepted, because the FSM is already in IDLE.
- Minimum transaction is one data byte; a zero-length transaction is not supported.
- Timing, CLK_DIV=D, N data bytes, no stalls:
  - busy width = D*(3 + 36*(2+N) + 3) cycles.
  - D=4, N=1: 456 cycles.
- sda_oe changes only while SCL is low, except in START and STOP.
- Bit counter is 3 bits and wraps 7->0 at the ACK entry; the byte shift register is 8 bits.

Test Plan:
- Single byte, D=4, ctrl=8'h00, din=8'hAE, last=1, slave always ACKs:
  - SDA decodes 7A,00,AE with 3 ACK slots.
  - busy high exactly 456 cycles; one done pulse; nack=0; one din_ready pulse.
- Stream of 3 bytes 8'h40, then 8'h01,8'h02,8'h03 (last on 03):
  - Exactly 3 din_ready pulses, each at a byte boundary.
  - Decoded bytes 7A,40,01,02,03.
  - busy = 4*(6+36*5) = 744 cycles.
- Stall: din_valid low for 100 cycles at the second byte boundary:
  - SCL held low and no line toggles during the stall.
  - busy extended by exactly 100 cycles.
  - Data intact.
- NACK on the address byte (sda_in=1 in slot):
  - STOP follows immediately; nack=1; zero din_ready pulses; done pulses.
  - Next start clears nack.
- CHECK_ACK=0 with NACK on every slot: full transaction completes; nack stays 0.
- Async reset asserted mid-DATA bit:
  - scl_oe=0, sda_oe=0, busy=0 within the same cycle (no clock edge needed).
  - A subsequent start runs a clean transaction.
